// File: rtl/logic_unit_sweep_if.sv
// logic_unit_sweep_if: stream operands/results plus self-test control for logic_unit_sweep
interface logic_unit_sweep_if #(parameter int WIDTH = 4);
  localparam int ACC_W = 2 * WIDTH + 8;
  logic [1:0]       op;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in1;
  logic [WIDTH-1:0] in2;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out1;
  logic [WIDTH-1:0] out2;
  logic             start;
  logic             busy;
  logic             done;
  logic [ACC_W-1:0] sweep_sum;
  modport master (
    output op, in_valid, in1, in2, out_ready, start,
    input  in_ready, out_valid, out1, out2, busy, done, sweep_sum
  );
  modport slave (
    input  op, in_valid, in1, in2, out_ready, start,
    output in_ready, out_valid, out1, out2, busy, done, sweep_sum
  );
endinterface

// File: rtl/logic_unit_sweep.sv
// logic_unit_sweep: registered per-bit logic unit with valid/ready stream and exhaustive-sweep popcount self-test
module logic_unit_sweep #(
  parameter int WIDTH = 4
) (
  input logic           clk,
  input logic           rst,
  logic_unit_sweep_if.slave bus
);
  localparam int ACC_W = 2 * WIDTH + 8;
  localparam int CW = 2 * WIDTH;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SWEEP = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  function automatic logic [WIDTH-1:0] fn(input logic [1:0] f, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    return f == 2'b00 ? a ^ b : f == 2'b01 ? a & b : f == 2'b10 ? a | b : ~(a ^ b);
  endfunction
  function automatic logic [ACC_W-1:0] pop(input logic [WIDTH-1:0] v);
    logic [ACC_W-1:0] p;
    p = '0;
    for (int i = 0; i < WIDTH; i++) p = p + ACC_W'(v[i]);
    return p;
  endfunction
  logic [1:0]       state_q, state_d;
  logic [1:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out1_q, out1_d;
  logic [WIDTH-1:0] out2_q, out2_d;
  logic             idle, in_ready, accept;
  assign idle = state_q == IDLE;
  assign in_ready = idle & ~bus.start & (~out_valid_q | bus.out_ready);
  assign accept = bus.in_valid & in_ready;
  always_comb begin
    out_valid_d = accept ? 1'b1 : bus.out_ready ? 1'b0 : out_valid_q;
    out1_d = accept ? fn(bus.op, bus.in1, bus.in2) : out1_q;
    out2_d = accept ? ~bus.in2 : out2_q;
  end
  // counter supplies {a,b} with a in the upper half; all-ones is the final pair
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    cnt_d = cnt_q;
    sum_d = sum_q;
    if (idle && bus.start) begin
      state_d = SWEEP;
      op_d = bus.op;
      cnt_d = '0;
      sum_d = '0;
    end else if (state_q == SWEEP) begin
      sum_d = sum_q + pop(fn(op_q, cnt_q[CW-1:WIDTH], cnt_q[WIDTH-1:0]));
      cnt_d = cnt_q + CW'(1);
      state_d = &cnt_q ? DONE : SWEEP;
    end else if (!idle) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_q <= '0;
      cnt_q <= '0;
      sum_q <= '0;
      out_valid_q <= 1'b0;
      out1_q <= '0;
      out2_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      cnt_q <= cnt_d;
      sum_q <= sum_d;
      out_valid_q <= out_valid_d;
      out1_q <= out1_d;
      out2_q <= out2_d;
    end
  end
  assign bus.in_ready = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out1 = out1_q;
  assign bus.out2 = out2_q;
  assign bus.busy = state_q == SWEEP;
  assign bus.done = state_q == DONE;
  assign bus.sweep_sum = sum_q;
endmodule

// File: tb/tb_logic_unit_sweep.sv
// tb_logic_unit_sweep: directed checks of stream path (WIDTH=4) and self-test sweep (WIDTH=2 and 4)
module tb_logic_unit_sweep;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int vectors = 0;
  int miscompares = 0;
  logic_unit_sweep_if #(.WIDTH(4)) b4();
  logic_unit_sweep_if #(.WIDTH(2)) b2();
  logic_unit_sweep #(.WIDTH(4)) u4 (.clk(clk), .rst(rst), .bus(b4));
  logic_unit_sweep #(.WIDTH(2)) u2 (.clk(clk), .rst(rst), .bus(b2));
  always #5 clk = ~clk;
  initial begin
    #100000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1);
  end
  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    vectors++; if (b4.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %b exp 0", b4.out_valid); end
    vectors++; if (b4.out1 !== 4'h0 || b4.out2 !== 4'h0) begin miscompares++; $display("FAIL rst_out got %h/%h exp 0/0", b4.out1, b4.out2); end
    vectors++; if (b4.busy !== 1'b0 || b4.done !== 1'b0) begin miscompares++; $display("FAIL rst_busy_done got %b%b exp 00", b4.busy, b4.done); end
    vectors++; if (b4.sweep_sum !== 16'h0 || b2.sweep_sum !== 12'h0) begin miscompares++; $display("FAIL rst_sum got %h/%h exp 0/0", b4.sweep_sum, b2.sweep_sum); end
    vectors++; if (b4.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_in_ready got %b exp 1", b4.in_ready); end
    rst = 1'b0;
  endtask
  task automatic test_stream;
    logic [1:0] ops[4] = '{2'b00, 2'b01, 2'b10, 2'b11};
    logic [3:0] exp[4] = '{4'h6, 4'h8, 4'hE, 4'h9};
    b4.out_ready = 1'b1;
    b4.in1 = 4'hC;
    b4.in2 = 4'hA;
    b4.in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      b4.op = ops[i];
      @(negedge clk);
      vectors++; if (b4.out_valid !== 1'b1 || b4.out1 !== exp[i] || b4.out2 !== 4'h5) begin miscompares++; $display("FAIL stream_op%0d got v=%b out1=%h out2=%h exp v=1 out1=%h out2=5", i, b4.out_valid, b4.out1, b4.out2, exp[i]); end
    end
    b4.in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (b4.out_valid !== 1'b0) begin miscompares++; $display("FAIL stream_drain got %b exp 0", b4.out_valid); end
  endtask
  task automatic test_stall;
    b4.out_ready = 1'b0;
    b4.op = 2'b00;
    b4.in1 = 4'hC;
    b4.in2 = 4'hA;
    b4.in_valid = 1'b1;
    @(negedge clk);
    b4.op = 2'b01;
    b4.in1 = 4'hF;
    b4.in2 = 4'hF;
    vectors++; if (b4.in_ready !== 1'b0) begin miscompares++; $display("FAIL stall_in_ready got %b exp 0", b4.in_ready); end
    @(negedge clk);
    vectors++; if (b4.out_valid !== 1'b1 || b4.out1 !== 4'h6 || b4.out2 !== 4'h5) begin miscompares++; $display("FAIL stall_hold got v=%b %h/%h exp 1 6/5", b4.out_valid, b4.out1, b4.out2); end
    b4.out_ready = 1'b1;
    @(negedge clk);
    vectors++; if (b4.out_valid !== 1'b1 || b4.out1 !== 4'hF || b4.out2 !== 4'h0) begin miscompares++; $display("FAIL stall_release got v=%b %h/%h exp 1 f/0", b4.out_valid, b4.out1, b4.out2); end
    b4.in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (b4.out_valid !== 1'b0) begin miscompares++; $display("FAIL stall_drain got %b exp 0", b4.out_valid); end
  endtask
  task automatic test_sweep(input logic [1:0] op, input int exp, input bit poke);
    int n = 0;
    b2.op = op;
    b2.start = 1'b1;
    @(negedge clk);
    b2.start = 1'b0;
    while (b2.busy === 1'b1 && n < 40) begin
      n++;
      vectors++; if (b2.done !== 1'b0) begin miscompares++; $display("FAIL sweep_done_early got %b exp 0", b2.done); end
      if (poke) begin
        b2.op = n == 3 ? ~op : b2.op;
        b2.start = n == 5;
      end
      @(negedge clk);
    end
    b2.start = 1'b0;
    vectors++; if (n !== 16) begin miscompares++; $display("FAIL sweep_busy_cycles op=%0d got %0d exp 16", op, n); end
    vectors++; if (b2.done !== 1'b1) begin miscompares++; $display("FAIL sweep_done op=%0d got %b exp 1", op, b2.done); end
    vectors++; if (b2.sweep_sum !== 12'(exp)) begin miscompares++; $display("FAIL sweep_sum op=%0d got %0d exp %0d", op, b2.sweep_sum, exp); end
    @(negedge clk);
    vectors++; if (b2.done !== 1'b0 || b2.busy !== 1'b0 || b2.sweep_sum !== 12'(exp)) begin miscompares++; $display("FAIL sweep_after op=%0d got done=%b busy=%b sum=%0d exp 0 0 %0d", op, b2.done, b2.busy, b2.sweep_sum, exp); end
  endtask
  task automatic test_start_priority;
    int n = 0;
    b4.out_ready = 1'b0;
    b4.op = 2'b00;
    b4.in1 = 4'hC;
    b4.in2 = 4'hA;
    b4.in_valid = 1'b1;
    @(negedge clk);
    b4.op = 2'b01;
    b4.in1 = 4'hF;
    b4.in2 = 4'hF;
    b4.start = 1'b1;
    b4.out_ready = 1'b1;
    vectors++; if (b4.in_ready !== 1'b0) begin miscompares++; $display("FAIL prio_in_ready got %b exp 0", b4.in_ready); end
    @(negedge clk);
    b4.start = 1'b0;
    b4.in_valid = 1'b0;
    vectors++; if (b4.busy !== 1'b1 || b4.out_valid !== 1'b0 || b4.out1 !== 4'h6) begin miscompares++; $display("FAIL prio_beat got busy=%b v=%b out1=%h exp 1 0 6", b4.busy, b4.out_valid, b4.out1); end
    while (b4.done !== 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    vectors++; if (n !== 256 || b4.sweep_sum !== 16'd256) begin miscompares++; $display("FAIL prio_sweep4 got cycles=%0d sum=%0d exp 256 256", n, b4.sweep_sum); end
  endtask
  task automatic test_reset_mid;
    int n = 0;
    b2.out_ready = 1'b0;
    b2.op = 2'b01;
    b2.in1 = 2'h3;
    b2.in2 = 2'h1;
    b2.in_valid = 1'b1;
    @(negedge clk);
    b2.in_valid = 1'b0;
    b2.op = 2'b10;
    b2.start = 1'b1;
    @(negedge clk);
    b2.start = 1'b0;
    repeat (4) @(negedge clk);
    vectors++; if (b2.busy !== 1'b1 || b2.out_valid !== 1'b1 || b2.out1 !== 2'h1) begin miscompares++; $display("FAIL mid_pre got busy=%b v=%b out1=%h exp 1 1 1", b2.busy, b2.out_valid, b2.out1); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++; if (b2.busy !== 1'b0 || b2.sweep_sum !== 12'h0 || b2.out_valid !== 1'b0) begin miscompares++; $display("FAIL mid_rst got busy=%b sum=%0d v=%b exp 0 0 0", b2.busy, b2.sweep_sum, b2.out_valid); end
    repeat (20) begin
      @(negedge clk);
      if (b2.done === 1'b1) n++;
    end
    vectors++; if (n !== 0) begin miscompares++; $display("FAIL mid_no_done got %0d pulses exp 0", n); end
    b2.out_ready = 1'b1;
  endtask
  initial begin
    b4.op = 2'b00; b4.in_valid = 1'b0; b4.in1 = '0; b4.in2 = '0; b4.out_ready = 1'b0; b4.start = 1'b0;
    b2.op = 2'b00; b2.in_valid = 1'b0; b2.in1 = '0; b2.in2 = '0; b2.out_ready = 1'b1; b2.start = 1'b0;
    test_reset;
    test_stream;
    test_stall;
    test_sweep(2'b00, 16, 1'b0);
    test_sweep(2'b01, 8, 1'b1);
    test_sweep(2'b10, 24, 1'b0);
    test_sweep(2'b11, 16, 1'b0);
    test_start_priority;
    test_reset_mid;
    test_sweep(2'b10, 24, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
